// File: rtl/block_align_if.sv
// +--------------------------------------------------------------------------+
// | block_align_if : operand/result handshake bundle of the FP align stage   |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

interface block_align_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] A;
  logic [31:0] B;
  logic        op;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  E_S;
  logic [26:0] M_L;
  logic [26:0] M_SM;
  logic        S_G;
  logic        eff_sub;
  logic        eq;
  logic [1:0]  special;

  modport master (
    output in_valid, A, B, op, out_ready,
    input  in_ready, out_valid, E_S, M_L, M_SM, S_G, eff_sub, eq, special
  );

  modport slave (
    input  in_valid, A, B, op, out_ready,
    output in_ready, out_valid, E_S, M_L, M_SM, S_G, eff_sub, eq, special
  );
endinterface

`default_nettype wire

// File: rtl/block_align.sv
// +--------------------------------------------------------------------------+
// | block_align : FP add/sub pre-normalization (swap + iterative align)      |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module block_align #(
  parameter int SHIFT_STEP = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  block_align_if.slave  bus
);

  localparam logic [4:0] STEP    = 5'(SHIFT_STEP);
  localparam logic [4:0] MAX_SH  = 5'd27;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWAP  = 2'd1,
    ALIGN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] a_q, a_d, b_q, b_d;
  logic        op_q, op_d;
  logic [7:0]  e_s_q, e_s_d;
  logic [26:0] m_l_q, m_l_d, m_sm_q, m_sm_d;
  logic        s_g_q, s_g_d, eff_sub_q, eff_sub_d, eq_q, eq_d;
  logic [1:0]  special_q, special_d;
  logic [4:0]  rem_q, rem_d;

  // Unpacked view of the registered operands (B sign already op-adjusted)
  logic        sign_a, sign_b;
  logic [7:0]  exp_a, exp_b;
  logic [26:0] man_a, man_b;
  logic        nan_a, nan_b, inf_a, inf_b;
  logic        b_big, eq_w, eff_sub_w;
  logic        sign_l;
  logic [7:0]  exp_l, exp_sm, diff;
  logic [26:0] man_l, man_sm;
  logic [4:0]  rem_init;

  assign sign_a    = a_q[31];
  assign sign_b    = b_q[31] ^ op_q;
  assign exp_a     = (a_q[30:23] == 8'd0) ? 8'd1 : a_q[30:23];
  assign exp_b     = (b_q[30:23] == 8'd0) ? 8'd1 : b_q[30:23];
  assign man_a     = {|a_q[30:23], a_q[22:0], 3'b000};
  assign man_b     = {|b_q[30:23], b_q[22:0], 3'b000};
  assign nan_a     = (&a_q[30:23]) & (|a_q[22:0]);
  assign nan_b     = (&b_q[30:23]) & (|b_q[22:0]);
  assign inf_a     = (&a_q[30:23]) & ~(|a_q[22:0]);
  assign inf_b     = (&b_q[30:23]) & ~(|b_q[22:0]);
  assign b_big     = b_q[30:0] > a_q[30:0];
  assign eq_w      = b_q[30:0] == a_q[30:0];
  assign eff_sub_w = sign_a ^ sign_b;
  assign sign_l    = b_big ? sign_b : sign_a;
  assign exp_l     = b_big ? exp_b : exp_a;
  assign exp_sm    = b_big ? exp_a : exp_b;
  assign man_l     = b_big ? man_b : man_a;
  assign man_sm    = b_big ? man_a : man_b;
  // Larger magnitude always has the larger-or-equal effective exponent
  assign diff      = exp_l - exp_sm;
  assign rem_init  = (diff > 8'(MAX_SH)) ? MAX_SH : diff[4:0];

  logic [4:0]  k;
  logic [26:0] shifted;
  logic        lost;

  always_comb begin
    k       = (rem_q > STEP) ? STEP : rem_q;
    shifted = m_sm_q >> k;
    lost    = 1'b0;
    for (int i = 0; i < 27; i++) begin
      if (i < int'(k)) lost = lost | m_sm_q[i];
    end
  end

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    op_d      = op_q;
    e_s_d     = e_s_q;
    m_l_d     = m_l_q;
    m_sm_d    = m_sm_q;
    s_g_d     = s_g_q;
    eff_sub_d = eff_sub_q;
    eq_d      = eq_q;
    special_d = special_q;
    rem_d     = rem_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          a_d     = bus.A;
          b_d     = bus.B;
          op_d    = bus.op;
          state_d = SWAP;
        end
      end
      SWAP: begin
        e_s_d     = exp_l;
        m_l_d     = man_l;
        m_sm_d    = man_sm;
        rem_d     = rem_init;
        eq_d      = eq_w;
        eff_sub_d = eff_sub_w;
        s_g_d     = (eq_w & eff_sub_w) ? 1'b0 : sign_l;
        if (nan_a | nan_b | (inf_a & inf_b & eff_sub_w)) begin
          special_d = 2'b10;
        end else if (inf_a | inf_b) begin
          special_d = 2'b01;
          s_g_d     = inf_a ? sign_a : sign_b;
        end else begin
          special_d = 2'b00;
        end
        state_d = (rem_init != 5'd0) ? ALIGN : DONE;
      end
      ALIGN: begin
        // Bit 0 is the sticky position: everything shifted past it folds in
        m_sm_d = shifted | {26'd0, lost};
        rem_d  = rem_q - k;
        if (rem_q == k) state_d = DONE;
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      op_q      <= 1'b0;
      e_s_q     <= '0;
      m_l_q     <= '0;
      m_sm_q    <= '0;
      s_g_q     <= 1'b0;
      eff_sub_q <= 1'b0;
      eq_q      <= 1'b0;
      special_q <= '0;
      rem_q     <= '0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      op_q      <= op_d;
      e_s_q     <= e_s_d;
      m_l_q     <= m_l_d;
      m_sm_q    <= m_sm_d;
      s_g_q     <= s_g_d;
      eff_sub_q <= eff_sub_d;
      eq_q      <= eq_d;
      special_q <= special_d;
      rem_q     <= rem_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE) & rst_n;
  assign bus.out_valid = (state_q == DONE);
  assign bus.E_S       = e_s_q;
  assign bus.M_L       = m_l_q;
  assign bus.M_SM      = m_sm_q;
  assign bus.S_G       = s_g_q;
  assign bus.eff_sub   = eff_sub_q;
  assign bus.eq        = eq_q;
  assign bus.special   = special_q;

endmodule

`default_nettype wire

// File: tb/tb_block_align.sv
// +--------------------------------------------------------------------------+
// | tb_block_align : directed scoreboard bench for block_align               |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_block_align;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  block_align_if bus ();
  block_align_if bus1 ();

  block_align #(.SHIFT_STEP(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  block_align #(.SHIFT_STEP(1)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1.slave)
  );

  typedef struct {
    logic [7:0]  e_s;
    logic [26:0] m_l;
    logic [26:0] m_sm;
    logic        s_g;
    logic        eff_sub;
    logic        eq;
    logic [1:0]  special;
    int          lat;
  } exp_t;

  exp_t sb_q[$];
  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Reference: one wide shift with a sticky OR, rather than stepwise
  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b,
                                 input logic o, input int step);
    exp_t        e;
    logic        sa, sb, nan_a, nan_b, inf_a, inf_b, bbig, sl;
    logic [7:0]  xa, xb, el, es;
    logic [26:0] ma, mb, ml, ms;
    logic [53:0] wide;
    int          d, sh;
    sa    = a[31];
    sb    = b[31] ^ o;
    xa    = (a[30:23] == 0) ? 8'd1 : a[30:23];
    xb    = (b[30:23] == 0) ? 8'd1 : b[30:23];
    ma    = {(a[30:23] != 0), a[22:0], 3'b000};
    mb    = {(b[30:23] != 0), b[22:0], 3'b000};
    nan_a = (a[30:23] == 8'hFF) && (a[22:0] != 0);
    nan_b = (b[30:23] == 8'hFF) && (b[22:0] != 0);
    inf_a = (a[30:23] == 8'hFF) && (a[22:0] == 0);
    inf_b = (b[30:23] == 8'hFF) && (b[22:0] == 0);
    bbig  = b[30:0] > a[30:0];
    el    = bbig ? xb : xa;
    es    = bbig ? xa : xb;
    ml    = bbig ? mb : ma;
    ms    = bbig ? ma : mb;
    sl    = bbig ? sb : sa;
    d     = int'(el) - int'(es);
    sh    = (d > 27) ? 27 : d;
    wide  = {ms, 27'd0} >> sh;
    e.e_s     = el;
    e.m_l     = ml;
    e.m_sm    = wide[53:27] | {26'd0, (wide[26:0] != 0)};
    e.eff_sub = sa ^ sb;
    e.eq      = (a[30:0] == b[30:0]);
    e.s_g     = (e.eq && e.eff_sub) ? 1'b0 : sl;
    if (nan_a || nan_b || (inf_a && inf_b && e.eff_sub)) e.special = 2'b10;
    else if (inf_a || inf_b) begin
      e.special = 2'b01;
      e.s_g     = inf_a ? sa : sb;
    end else e.special = 2'b00;
    e.lat = 2 + (sh + step - 1) / step;
    return e;
  endfunction

  task automatic check_out(input exp_t e, input string tag);
    check({tag, ".E_S"}, 32'(bus.E_S), 32'(e.e_s));
    check({tag, ".M_L"}, 32'(bus.M_L), 32'(e.m_l));
    check({tag, ".M_SM"}, 32'(bus.M_SM), 32'(e.m_sm));
    check({tag, ".eff_sub"}, 32'(bus.eff_sub), 32'(e.eff_sub));
    check({tag, ".eq"}, 32'(bus.eq), 32'(e.eq));
    check({tag, ".special"}, 32'(bus.special), 32'(e.special));
    if (e.special != 2'b10) check({tag, ".S_G"}, 32'(bus.S_G), 32'(e.s_g));
  endtask

  // Present an operation at a negedge; returns at the negedge after the accept edge
  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic o, input bit hold);
    int n = 0;
    sb_q.push_back(model(a, b, o, 8));
    bus.A        = a;
    bus.B        = b;
    bus.op       = o;
    bus.in_valid = 1'b1;
    while (!bus.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("accept", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    if (!hold) bus.in_valid = 1'b0;
  endtask

  task automatic wait_out(output int lat);
    lat = 1;
    while (!bus.out_valid && lat < 200) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic finish_op(input string tag);
    int   lat;
    exp_t e;
    wait_out(lat);
    e = sb_q.pop_front();
    check({tag, ".latency"}, 32'(lat), 32'(e.lat));
    check_out(e, tag);
    @(negedge clk);
  endtask

  logic [31:0] stim_a [10] = '{32'h3F800000, 32'h3F800000, 32'h4D800000, 32'h3F800000,
                               32'h7F800000, 32'h7F800000, 32'h7FC00000, 32'hC0000000,
                               32'h00000001, 32'h3F800003};
  logic [31:0] stim_b [10] = '{32'h3F800000, 32'h41000000, 32'h3F800001, 32'h3F800000,
                               32'h7F800000, 32'h3F800000, 32'h3F800000, 32'h3F800000,
                               32'h00800000, 32'h4B000000};
  logic        stim_op[10] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

  initial begin
    exp_t e1;
    int   lat;
    bit   seen;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    bus.A         = '0;
    bus.B         = '0;
    bus.op        = 1'b0;
    bus1.in_valid  = 1'b0;
    bus1.out_ready = 1'b1;
    bus1.A         = '0;
    bus1.B         = '0;
    bus1.op        = 1'b0;
    repeat (2) @(negedge clk);

    // Reset state
    check("rst.in_ready", 32'(bus.in_ready), 32'd0);
    check("rst.out_valid", 32'(bus.out_valid), 32'd0);
    check("rst.M_L", 32'(bus.M_L), 32'd0);
    check("rst.M_SM", 32'(bus.M_SM), 32'd0);
    check("rst.flags", {bus.E_S, bus.S_G, bus.eff_sub, bus.eq, bus.special}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst.in_ready", 32'(bus.in_ready), 32'd1);

    // Directed operations through the scoreboard, out_ready held high
    for (int i = 0; i < 10; i++) begin
      send(stim_a[i], stim_b[i], stim_op[i], 1'b0);
      finish_op($sformatf("op%0d", i));
    end

    // Backpressure with a pending second request
    bus.out_ready = 1'b0;
    send(32'h3F800000, 32'h41000000, 1'b0, 1'b0);
    wait_out(lat);
    check("bp.latency", 32'(lat), 32'd3);
    e1 = sb_q[0];
    bus.A        = 32'h40400000;
    bus.B        = 32'hC0000000;
    bus.op       = 1'b1;
    bus.in_valid = 1'b1;
    sb_q.push_back(model(32'h40400000, 32'hC0000000, 1'b1, 8));
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check_out(e1, "bp.hold");
      check("bp.in_ready", 32'(bus.in_ready), 32'd0);
      check("bp.out_valid", 32'(bus.out_valid), 32'd1);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    void'(sb_q.pop_front());
    check("bp.release.in_ready", 32'(bus.in_ready), 32'd1);
    check("bp.release.out_valid", 32'(bus.out_valid), 32'd0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    finish_op("bp.second");

    // SHIFT_STEP=1 instance: 27 align cycles
    bus1.A        = 32'h4D800000;
    bus1.B        = 32'h3F800001;
    bus1.op       = 1'b1;
    bus1.in_valid = 1'b1;
    begin
      int n = 0;
      while (!bus1.in_ready && n < 50) begin
        @(negedge clk);
        n++;
      end
    end
    @(negedge clk);
    bus1.in_valid = 1'b0;
    lat = 1;
    while (!bus1.out_valid && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    check("step1.latency", 32'(lat), 32'd29);
    check("step1.M_SM", 32'(bus1.M_SM), 32'd1);
    check("step1.E_S", 32'(bus1.E_S), 32'h9B);
    check("step1.eff_sub", 32'(bus1.eff_sub), 32'd1);
    @(negedge clk);

    // Reset in the middle of ALIGN discards the operation
    send(32'h4D800000, 32'h3F800001, 1'b1, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    void'(sb_q.pop_back());
    check("midrst.in_ready_low", 32'(bus.in_ready), 32'd0);
    check("midrst.M_L", 32'(bus.M_L), 32'd0);
    check("midrst.M_SM", 32'(bus.M_SM), 32'd0);
    check("midrst.flags", {bus.E_S, bus.S_G, bus.eff_sub, bus.eq, bus.special}, 32'd0);
    rst_n = 1'b1;
    #1;
    check("midrst.in_ready", 32'(bus.in_ready), 32'd1);
    seen = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (bus.out_valid) seen = 1'b1;
    end
    check("midrst.no_out_valid", 32'(seen), 32'd0);
    send(32'h4D800000, 32'h3F800001, 1'b1, 1'b0);
    finish_op("midrst.after");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
